bmp_write_sched: RTL and testbench
==================================

BMP_WRITE_SCHED -- requirements
Module: bmp_write_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 768, image width in pixels (even).
REQ-002 SHALL have parameter HEIGHT, default 512, image height in rows.
REQ-003 SHALL have parameter AW, default 21, byte-address width, with 2^AW >= WIDTH*HEIGHT*3.
REQ-004 SHALL have port HCLK  input  1  clock; reset HRESETn, asynchronous, active-low; clock HCLK.
REQ-005 SHALL have port HRESETn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  2  per-requester frame request, one bit per requester.
REQ-007 SHALL have port valid  input  2  per-requester pixel-pair beat valid.
REQ-008 SHALL have port data0  input  48  requester 0 pixel pair {R0,G0,B0,R1,G1,B1}, R0 in [47:40].
REQ-009 SHALL have port data1  input  48  requester 1 pixel pair, same packing as data0.
REQ-010 SHALL have port ready  output  2  beat accept, one bit per requester.
REQ-011 SHALL have port grant  output  2  one-hot frame owner; all zero when idle.
REQ-012 SHALL have port wr_en  output  1  write strobe to the frame buffer.
REQ-013 SHALL have port wr_addr  output  AW  byte address of B0 of the pixel pair.
REQ-014 SHALL have port wr_data  output  48  registered copy of the accepted beat, packing unchanged.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse when the frame is complete.
REQ-016 SHALL have port busy  output  1  high in STREAM and DONE.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, STREAM, DONE.
REQ-018 IDLE: when req!=0, SHALL register grant and move to STREAM; one request wins; on req==2'b11 the requester not granted last wins.
REQ-019 SHALL drive ready[g]=1 only in STREAM, and only for the granted index g; the other ready bit SHALL be 0.
REQ-020 A beat SHALL be accepted when valid[g]&ready[g]; valid on the non-granted requester SHALL be ignored.
REQ-021 Counters col (0..WIDTH/2-1) and row (0..HEIGHT-1) SHALL advance per accepted beat; col wraps to 0 and row increments.
REQ-022 SHALL compute wr_addr = WIDTH*3*(HEIGHT-1-row) + 6*col, giving bottom-up BMP order, using the pre-increment counter values.
REQ-023 For each accepted beat, wr_en, wr_addr and wr_data SHALL be valid exactly 1 cycle after acceptance; wr_en SHALL be 0 otherwise.
REQ-024 On acceptance at row=HEIGHT-1 and col=WIDTH/2-1, SHALL enter DONE, drop ready, and clear the counters.
REQ-025 DONE SHALL last 1 cycle with frame_done=1, coinciding with the last wr_en; the FSM then returns to IDLE and grant returns to 0.
REQ-026 Deasserting req mid-frame SHALL NOT abort the frame; the owner keeps grant until the frame completes.
REQ-027 A new req arriving in DONE SHALL be serviced from IDLE the next cycle; back-to-back frames therefore have a 2-cycle gap.
REQ-028 Address arithmetic SHALL be unsigned, AW bits wide, with no intermediate truncation.

Reset
REQ-029 On HRESETn low, SHALL set: state IDLE, grant=0, ready=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, busy=0, counters=0, last-grant=1 (so requester 0 wins the first tie).
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release the FSM SHALL be in IDLE and issue no pending write.

Structure
REQ-031 Shared package img_pkg SHALL hold the default WIDTH/HEIGHT, the BMP header length (54), and the 48-bit pixel-pair packing field offsets.
REQ-032 Counters and address generation SHALL live in sub-module bmp_addr_gen (inputs: step, clear; outputs: wr_addr, last).

Verification (WIDTH=8, HEIGHT=4, AW=21)
REQ-033 Single frame: req=01 with valid held high -> grant=01 the next cycle; 16 writes at addrs 72,78,84,90,48,...,18; frame_done coincides with the addr-18 write.
REQ-034 Tie: req=11 after reset -> requester 0 served; req=11 held -> requester 1 served next, then requester 0 again.
REQ-035 Backpressure: valid[0] toggling 1/0 -> exactly 16 writes, with no address skipped or repeated.
REQ-036 Foreign valid: valid[1]=1 throughout requester 0's frame -> ready[1]=0 always, and no data1 value ever appears on wr_data.
REQ-037 Mid-frame reset after the 5th beat -> all outputs 0; the next frame restarts at addr 72.
REQ-038 Req drop: req[0] deasserted after the 1st beat -> the frame still completes its 16 writes and frame_done is pulsed.

Source files
------------

// File: rtl/img_pkg.sv
// img_pkg: shared image geometry, BMP header length, pixel-pair packing and scheduler states
package img_pkg;
  localparam int IMG_WIDTH = 768;
  localparam int IMG_HEIGHT = 512;
  localparam int BMP_HDR_LEN = 54;
  localparam int PX_BITS = 8;
  localparam int PX_R0 = 40;
  localparam int PX_G0 = 32;
  localparam int PX_B0 = 24;
  localparam int PX_R1 = 16;
  localparam int PX_G1 = 8;
  localparam int PX_B1 = 0;
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;
endpackage

// File: rtl/bmp_addr_gen.sv
// bmp_addr_gen: pixel-pair column/row counters and bottom-up BMP byte address
module bmp_addr_gen import img_pkg::*; #(
  parameter int WIDTH = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int AW = 21
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          step,
  input  logic          clear,
  output logic [AW-1:0] wr_addr,
  output logic          last
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH / 2 - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic w_col_end;
  assign w_col_end = r_col == COL_MAX;
  assign last = w_col_end && r_row == ROW_MAX;
  // Row 0 of the stream is the top image row, stored last in a BMP file.
  assign wr_addr = AW'(WIDTH * 3) * (AW'(HEIGHT - 1) - AW'(r_row)) + AW'(6) * AW'(r_col);
  // Advance column per beat, wrapping into the next row; clear wins over step.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (step) begin
      r_col <= w_col_end ? '0 : r_col + 1'b1;
      r_row <= w_col_end ? r_row + 1'b1 : r_row;
    end
  end
endmodule

// File: rtl/bmp_write_sched.sv
// bmp_write_sched: two-requester frame arbiter streaming pixel pairs into a bottom-up BMP buffer
module bmp_write_sched import img_pkg::*; #(
  parameter int WIDTH = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int AW = 21
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [1:0]    req,
  input  logic [1:0]    valid,
  input  logic [47:0]   data0,
  input  logic [47:0]   data1,
  output logic [1:0]    ready,
  output logic [1:0]    grant,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [47:0]   wr_data,
  output logic          frame_done,
  output logic          busy
);
  state_t r_state, w_next;
  logic [1:0] r_grant, w_pick;
  logic r_last;
  logic w_accept, w_last;
  logic [AW-1:0] w_addr;
  logic r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [47:0] r_wr_data;
  assign grant = r_grant;
  assign ready = r_state == S_STREAM ? r_grant : 2'b00;
  assign busy = r_state != S_IDLE;
  assign frame_done = r_state == S_DONE;
  assign wr_en = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign w_pick = req == 2'b11 ? (r_last ? 2'b01 : 2'b10) : req;
  assign w_accept = r_state == S_STREAM && |(valid & r_grant);
  bmp_addr_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW)) u_addr (
    .HCLK(HCLK), .HRESETn(HRESETn), .step(w_accept), .clear(w_accept && w_last),
    .wr_addr(w_addr), .last(w_last)
  );
  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // Next state: a frame runs to its final beat regardless of req, then one DONE cycle.
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE ? (|req ? S_STREAM : S_IDLE) :
             r_state == S_STREAM ? (w_accept && w_last ? S_DONE : S_STREAM) : S_IDLE;
  end
  // Latch the frame owner in IDLE and remember it for round-robin ties; release after DONE.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_grant <= 2'b00;
      r_last <= 1'b1;
    end else if (r_state == S_IDLE && |req) begin
      r_grant <= w_pick;
      r_last <= w_pick[1];
    end else if (r_state == S_DONE) begin
      r_grant <= 2'b00;
    end
  end
  // Register each accepted beat with its address for a one-cycle-later write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_en <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr <= w_addr;
        r_wr_data <= r_grant[1] ? data1 : data0;
      end
    end
  end
endmodule

// File: tb/tb_bmp_write_sched.sv
// tb_bmp_write_sched: randomized self-checking bench against a frame-level reference model
module tb_bmp_write_sched;
  localparam int W = 8;
  localparam int H = 4;
  localparam int AW = 21;
  localparam int BEATS = W * H / 2;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic [1:0] req = '0, valid = '0;
  logic [47:0] data0 = '0, data1 = '0;
  logic [1:0] ready, grant;
  logic wr_en, frame_done, busy;
  logic [AW-1:0] wr_addr;
  logic [47:0] wr_data;
  int checks = 0, errors = 0;
  int m_state = 0, m_owner = 0, m_beats = 0, m_prev = 1;
  int writes = 0, dones = 0;

  bmp_write_sched #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .valid(valid), .data0(data0), .data1(data1),
    .ready(ready), .grant(grant), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [AW-1:0] beat_addr(input int k);
    return AW'(W * 3 * (H - 1 - k / (W / 2)) + 6 * (k % (W / 2)));
  endfunction

  task automatic step(input logic [1:0] rq, input logic [1:0] vl, input logic [47:0] d0, input logic [47:0] d1);
    logic acc, e_done;
    logic [AW-1:0] e_addr;
    logic [47:0] e_data;
    logic [1:0] e_grant;
    req = rq; valid = vl; data0 = d0; data1 = d1;
    acc = m_state == 1 && vl[m_owner];
    e_done = 1'b0;
    e_addr = beat_addr(m_beats);
    e_data = m_owner == 1 ? d1 : d0;
    if (m_state == 0 && rq != 2'b00) begin
      m_owner = rq == 2'b11 ? (m_prev == 1 ? 0 : 1) : (rq == 2'b10 ? 1 : 0);
      m_prev = m_owner;
      m_state = 1;
    end else if (m_state == 1 && acc) begin
      m_beats++;
      if (m_beats == BEATS) begin
        m_beats = 0;
        m_state = 2;
        e_done = 1'b1;
      end
    end else if (m_state == 2) begin
      m_state = 0;
    end
    e_grant = m_state != 0 ? 2'(1 << m_owner) : 2'b00;
    @(posedge HCLK);
    #1;
    checks++;
    if (wr_en !== acc) begin errors++; $display("FAIL wr_en got %b want %b", wr_en, acc); end
    if (acc) begin
      checks++;
      if (wr_addr !== e_addr) begin errors++; $display("FAIL wr_addr got %0d want %0d", wr_addr, e_addr); end
      checks++;
      if (wr_data !== e_data) begin errors++; $display("FAIL wr_data got %h want %h", wr_data, e_data); end
    end
    checks++;
    if (frame_done !== e_done) begin errors++; $display("FAIL frame_done got %b want %b", frame_done, e_done); end
    checks++;
    if (grant !== e_grant) begin errors++; $display("FAIL grant got %b want %b", grant, e_grant); end
    checks++;
    if (ready !== (m_state == 1 ? e_grant : 2'b00)) begin errors++; $display("FAIL ready got %b want %b", ready, m_state == 1 ? e_grant : 2'b00); end
    checks++;
    if (busy !== (m_state != 0)) begin errors++; $display("FAIL busy got %b want %b", busy, m_state != 0); end
    writes += int'(wr_en);
    dones += int'(frame_done);
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    @(negedge HCLK);
    HRESETn = 1'b0;
    req = '0; valid = '0;
    #2;
    m_state = 0; m_beats = 0; m_prev = 1;
    checks++;
    if ({grant, ready, wr_en, frame_done, busy} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0", {grant, ready, wr_en, frame_done, busy});
    end
    checks++;
    if (wr_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", wr_addr); end
    checks++;
    if (wr_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", wr_data); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  // mode: 0 valid held, 1 owner valid toggling, 2 random valid; drop releases req after the first write.
  task automatic run_frame(input logic [1:0] rq0, input int mode, input bit drop, input int exp_owner);
    int n = 0;
    int w0 = writes, f0 = dones;
    bit started = 0;
    logic [1:0] rq, vl;
    while (n < 400) begin
      rq = drop && writes > w0 ? 2'b00 : rq0;
      vl = mode == 0 ? 2'b11 : mode == 1 ? {n[0], n[0]} : 2'($urandom);
      step(rq, vl, {1'b0, 47'($urandom)} ^ {16'h0, 32'($urandom)}, {1'b1, 47'($urandom)});
      if (!started && m_state != 0) begin
        started = 1;
        checks++;
        if (grant !== 2'(1 << exp_owner)) begin errors++; $display("FAIL owner got %b want %b", grant, 2'(1 << exp_owner)); end
      end
      n++;
      if (started && m_state == 0) break;
    end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL frame_timeout got %0d cycles want <400", n); end
    checks++;
    if (writes - w0 != BEATS) begin errors++; $display("FAIL frame_writes got %0d want %0d", writes - w0, BEATS); end
    checks++;
    if (dones - f0 != 1) begin errors++; $display("FAIL frame_pulses got %0d want 1", dones - f0); end
  endtask

  task automatic test_single();
    run_frame(2'b01, 0, 0, 0);
    repeat (3) step(2'b00, 2'b11, 48'($urandom), 48'($urandom));
  endtask

  task automatic test_tie();
    test_reset();
    run_frame(2'b11, 0, 0, 0);
    run_frame(2'b11, 0, 0, 1);
    run_frame(2'b11, 0, 0, 0);
    step(2'b00, 2'b00, '0, '0);
  endtask

  task automatic test_backpressure();
    run_frame(2'b01, 1, 0, 0);
  endtask

  task automatic test_foreign();
    run_frame(2'b01, 2, 0, 0);
  endtask

  task automatic test_req_drop();
    run_frame(2'b01, 0, 1, 0);
  endtask

  task automatic test_midreset();
    int n = 0;
    while (n < 50 && !(m_state == 1 && m_beats == 5)) begin
      step(2'b01, 2'b01, 48'($urandom), 48'($urandom));
      n++;
    end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL midreset_reach got %0d cycles want <50", n); end
    test_reset();
    step(2'b00, 2'b00, '0, '0);
    run_frame(2'b01, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_frame(2'b10, 0, 0, 1);
    run_frame(2'b10, 2, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) step(2'($urandom), 2'($urandom), 48'($urandom), 48'($urandom));
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_foreign();
    test_midreset();
    test_req_drop();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
